// File: rtl/sevenseg_scan_reader.sv
// Rebuilds BCD digits from a scanned 7-segment bus.
// Each digit commits after STABLE_SCANS matching samples.
module sevenseg_scan_reader #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_bad,
  output logic                    update,
  output logic                    collision
);

  localparam int CW = $clog2(STABLE_SCANS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SC = CW'(STABLE_SCANS);

  logic [6:0]    cand [NUM_DIGITS];
  logic [CW-1:0] cnt  [NUM_DIGITS];

  logic [3:0]    pop;
  logic [IW-1:0] idx;
  logic          accept;
  logic          coll;
  logic [6:0]    cur_cand;
  logic [CW-1:0] cur_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          match;
  logic          sat;
  logic          commit;
  logic [3:0]    dec_val;
  logic          dec_bad;
  logic          changed;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'h7E:   r = {1'b0, 4'd0};
      7'h30:   r = {1'b0, 4'd1};
      7'h6D:   r = {1'b0, 4'd2};
      7'h79:   r = {1'b0, 4'd3};
      7'h33:   r = {1'b0, 4'd4};
      7'h5B:   r = {1'b0, 4'd5};
      7'h5F:   r = {1'b0, 4'd6};
      7'h70:   r = {1'b0, 4'd7};
      7'h7F:   r = {1'b0, 4'd8};
      7'h7B:   r = {1'b0, 4'd9};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_en[i]) begin
        pop = pop + 4'd1;
        idx = IW'(i);
      end
    end
  end

  assign accept = sample_en && (pop == 4'd1);
  assign coll   = sample_en && (pop > 4'd1);

  always_comb begin
    cur_cand = cand[idx];
    cur_cnt  = cnt[idx];
    match    = (seg_in == cur_cand);
    sat      = (cur_cnt == SC);
    if (!match)   nxt_cnt = CW'(1);
    else if (sat) nxt_cnt = SC;
    else          nxt_cnt = cur_cnt + CW'(1);
    // only the transition into saturation commits
    commit   = accept && (nxt_cnt == SC) && !(match && sat);
    {dec_bad, dec_val} = decode(seg_in);
    changed  = (digits_out[4*idx +: 4] != dec_val) ||
               (digit_bad[idx] != dec_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out <= '0;
      digit_bad  <= '1;
      update     <= 1'b0;
      collision  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= 7'h00;
        cnt[i]  <= '0;
      end
    end else begin
      update    <= 1'b0;
      collision <= coll;
      if (accept) begin
        cand[idx] <= seg_in;
        cnt[idx]  <= nxt_cnt;
      end
      if (commit) begin
        digits_out[4*idx +: 4] <= dec_val;
        digit_bad[idx]         <= dec_bad;
        update                 <= changed;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Directed bench for sevenseg_scan_reader.
// Expected outputs are queued per step and popped after the edge.
module tb_sevenseg_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] digits_out;
  logic [3:0]  digit_bad;
  logic        update;
  logic        collision;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic        u;
    logic        c;
  } exp_t;

  exp_t sb[$];

  sevenseg_scan_reader #(.NUM_DIGITS(4), .STABLE_SCANS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
    .digits_out (digits_out),
    .digit_bad  (digit_bad),
    .update     (update),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] d, input logic [3:0] b,
                      input logic u, input logic c);
    exp_t e;
    e.d = d; e.b = b; e.u = u; e.c = c;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (digits_out === e.d) else begin
      errors++;
      $error("FAIL %s digits_out observed=%h expected=%h", tag, digits_out, e.d);
    end
    checks++;
    assert (digit_bad === e.b) else begin
      errors++;
      $error("FAIL %s digit_bad observed=%b expected=%b", tag, digit_bad, e.b);
    end
    checks++;
    assert (update === e.u) else begin
      errors++;
      $error("FAIL %s update observed=%b expected=%b", tag, update, e.u);
    end
    checks++;
    assert (collision === e.c) else begin
      errors++;
      $error("FAIL %s collision observed=%b expected=%b", tag, collision, e.c);
    end
  endtask

  task automatic step(input string tag, input logic en, input logic [3:0] dg,
                      input logic [6:0] sg, input logic [15:0] d,
                      input logic [3:0] b, input logic u, input logic c);
    @(negedge clk);
    sample_en = en;
    dig_en    = dg;
    seg_in    = sg;
    push(d, b, u, c);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; dig_en = '0; seg_in = '0;
    #12;
    push(16'h0000, 4'b1111, 1'b0, 1'b0);
    pop_cmp("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("d0_1a",  1, 4'b0001, 7'h30, 16'h0000, 4'b1111, 0, 0);
    step("d0_1b",  1, 4'b0001, 7'h30, 16'h0001, 4'b1110, 1, 0);
    step("idle1",  0, 4'b0000, 7'h00, 16'h0001, 4'b1110, 0, 0);

    step("f1_d0",  1, 4'b0001, 7'h7E, 16'h0001, 4'b1110, 0, 0);
    step("f1_d1",  1, 4'b0010, 7'h6D, 16'h0001, 4'b1110, 0, 0);
    step("f1_d2",  1, 4'b0100, 7'h79, 16'h0001, 4'b1110, 0, 0);
    step("f1_d3",  1, 4'b1000, 7'h5B, 16'h0001, 4'b1110, 0, 0);
    step("f2_d0",  1, 4'b0001, 7'h7E, 16'h0000, 4'b1110, 1, 0);
    step("f2_d1",  1, 4'b0010, 7'h6D, 16'h0020, 4'b1100, 1, 0);
    step("f2_d2",  1, 4'b0100, 7'h79, 16'h0320, 4'b1000, 1, 0);
    step("f2_d3",  1, 4'b1000, 7'h5B, 16'h5320, 4'b0000, 1, 0);
    step("f3_d0",  1, 4'b0001, 7'h7E, 16'h5320, 4'b0000, 0, 0);
    step("f3_d1",  1, 4'b0010, 7'h6D, 16'h5320, 4'b0000, 0, 0);
    step("f3_d2",  1, 4'b0100, 7'h79, 16'h5320, 4'b0000, 0, 0);
    step("f3_d3",  1, 4'b1000, 7'h5B, 16'h5320, 4'b0000, 0, 0);

    step("d2_5f",  1, 4'b0100, 7'h5F, 16'h5320, 4'b0000, 0, 0);
    step("d2_79",  1, 4'b0100, 7'h79, 16'h5320, 4'b0000, 0, 0);
    step("d2_5fa", 1, 4'b0100, 7'h5F, 16'h5320, 4'b0000, 0, 0);
    step("d2_5fb", 1, 4'b0100, 7'h5F, 16'h5620, 4'b0000, 1, 0);
    step("idle2",  0, 4'b0000, 7'h00, 16'h5620, 4'b0000, 0, 0);

    step("d1_01a", 1, 4'b0010, 7'h01, 16'h5620, 4'b0000, 0, 0);
    step("d1_01b", 1, 4'b0010, 7'h01, 16'h56F0, 4'b0010, 1, 0);
    step("d1_12a", 1, 4'b0010, 7'h12, 16'h56F0, 4'b0010, 0, 0);
    step("d1_12b", 1, 4'b0010, 7'h12, 16'h56F0, 4'b0010, 0, 0);

    step("d0_30a", 1, 4'b0001, 7'h30, 16'h56F0, 4'b0010, 0, 0);
    step("coll",   1, 4'b0101, 7'h30, 16'h56F0, 4'b0010, 0, 1);
    step("noden",  1, 4'b0000, 7'h30, 16'h56F0, 4'b0010, 0, 0);
    step("noen",   0, 4'b0001, 7'h30, 16'h56F0, 4'b0010, 0, 0);
    step("d0_30b", 1, 4'b0001, 7'h30, 16'h56F1, 4'b0010, 1, 0);

    step("d3_7ea", 1, 4'b1000, 7'h7E, 16'h56F1, 4'b0010, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    push(16'h0000, 4'b1111, 1'b0, 1'b0);
    #1;
    pop_cmp("midrst");
    sample_en = 1'b0;
    @(negedge clk);
    push(16'h0000, 4'b1111, 1'b0, 1'b0);
    pop_cmp("inrst");
    rst_n = 1'b1;

    step("d3_7eb", 1, 4'b1000, 7'h7E, 16'h0000, 4'b1111, 0, 0);
    step("d3_7ec", 1, 4'b1000, 7'h7E, 16'h0000, 4'b0111, 1, 0);
    step("d0_7fa", 1, 4'b0001, 7'h7F, 16'h0000, 4'b0111, 0, 0);
    step("d0_7fb", 1, 4'b0001, 7'h7F, 16'h0008, 4'b0110, 1, 0);
    step("d1_70a", 1, 4'b0010, 7'h70, 16'h0008, 4'b0110, 0, 0);
    step("d1_70b", 1, 4'b0010, 7'h70, 16'h0078, 4'b0100, 1, 0);
    step("d2_33a", 1, 4'b0100, 7'h33, 16'h0078, 4'b0100, 0, 0);
    step("d2_33b", 1, 4'b0100, 7'h33, 16'h0478, 4'b0000, 1, 0);
    step("d0_7ba", 1, 4'b0001, 7'h7B, 16'h0478, 4'b0000, 0, 0);
    step("d0_7bb", 1, 4'b0001, 7'h7B, 16'h0479, 4'b0000, 1, 0);
    step("idle3",  0, 4'b0000, 7'h00, 16'h0479, 4'b0000, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_reader.md
Name: sevenseg_scan_reader

Overview:
- Receiving end of the team's 7-segment display path. It watches a multiplexed, scanned segment bus (segment lines plus one-hot digit enables) and rebuilds the BCD value shown on each digit.
- A pattern is committed only after it has been stable for a set number of scans.
- Used as a display-readback checker and as a front end for panels that only expose segment lines.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (1..8).
- STABLE_SCANS, 2, consecutive identical samples of one digit required before commit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies seg_in/dig_en as a valid scan sample this cycle.
- seg_in  input  7  active-high segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  input  NUM_DIGITS  active-high one-hot digit select; bit i = digit i.
- digits_out  output  4*NUM_DIGITS  committed BCD values; digit i at [4i+3:4i].
- digit_bad  output  NUM_DIGITS  1 = committed pattern for digit i is not a decimal digit, or digit i has not been committed yet.
- update  output  1  one-cycle pulse when any digits_out/digit_bad bit changes.
- collision  output  1  one-cycle pulse when a sample has more than one dig_en bit set.

Behaviour:
- Reset (rst_n=0, async): digits_out=0, digit_bad=all 1, update=0, collision=0. Per-digit candidate pattern=7'h00, match count=0. Takes effect immediately, mid-scan included. No commit is carried across reset.
- Decode, combinational from seg_in:
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, each with bad=0.
  - Dash 01 (error/out-of-range pattern) and every other pattern -> value 4'hF, bad=1.
- Sample acceptance, per clk edge with sample_en=1:
  - dig_en one-hot: the sample targets digit i.
  - dig_en == 0: sample ignored, no state change.
  - dig_en with >1 bit set: sample ignored, collision=1 on the following cycle, candidates and counts untouched.
  - sample_en=0: nothing changes; counts are held, not cleared.
- Per-digit stability filter, on an accepted sample for digit i:
  - seg_in == candidate[i]: count[i] = min(count[i]+1, STABLE_SCANS).
  - Otherwise: candidate[i]=seg_in, count[i]=1.
  - Commit happens when count[i] reaches STABLE_SCANS on this sample (transition into STABLE_SCANS, including 0->1 when STABLE_SCANS=1). digits_out[i] and digit_bad[i] then take the decoded value of candidate[i].
  - Further matching samples once saturated cause no new commit.
  - A differing pattern restarts the count. The previously committed output is kept until the new pattern reaches STABLE_SCANS.
- Latency: outputs and the update pulse become visible in the cycle after the edge that registers the STABLE_SCANS-th consecutive matching sample.
- update pulses only if the committed value or bad flag differs from the current output. Recommitting an identical value gives no pulse.
- Only one digit can commit per cycle, so there are no simultaneous commits.
- Digits are independent. Samples for digit j never affect candidate[i] or count[i] for i≠j, so interleaved scanning is the normal case.
- Count width is clog2(STABLE_SCANS+1) bits, and the count saturates (never wraps).
- All outputs are registered.

Test Plan:
- After reset, check digits_out=0x0000, digit_bad=4'b1111, update=0. Then, with STABLE_SCANS=2, sample digit0 with seg_in=7'h30 twice -> digits_out[3:0]=1, digit_bad[0]=0, update high for exactly 1 cycle, one cycle after the second sample.
- Round-robin scan of 7E, 6D, 79, 5B on digits 0..3, two full frames -> digits_out=16'h5320, digit_bad=0000. A third identical frame produces no update pulse.
- Digit2 committed at 3. Apply 7'h5F once, then 7'h79, then 7'h5F twice -> digits_out digit2 stays 3 until the second consecutive 5F, then becomes 6.
- Sample digit1 with 7'h01 twice -> digit1 value 4'hF, digit_bad[1]=1, update pulses. Repeat with 7'h12 (garbage) -> same value and flag, and no update.
- dig_en=4'b0101 with sample_en=1 -> collision pulses 1 cycle, all outputs and counts unchanged. dig_en=0 or sample_en=0 -> no effect.
- One matching sample (count=1) for digit3, assert rst_n=0 mid-cycle -> outputs return to reset values immediately. After release, a single further sample does not commit.
